// File: rtl/sync_reg_qualify.sv
// sync_reg_qualify
// Stability qualifier that sits right after the register synchronizer. A
// multi-bit value already in the clk domain must hold for stable_cycles
// consecutive samples before it is accepted. This rejects the transient
// mixed-bit codes that skewed bit crossings can produce. Each accepted change
// is handed to the consumer over a valid/ack handshake, with a one-deep
// pending buffer behind the output register.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   in_reg       synchronized input value
//   out_reg      qualified value presented to the consumer
//   out_valid    out_reg holds an unacknowledged change
//   out_ack      consumer accepts out_reg (ignored while out_valid is low)
//   change_lost  sticky: a qualified change was overwritten before delivery
module sync_reg_qualify #(
  parameter int width         = 8,
  parameter int stable_cycles = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] in_reg,
  output logic [width-1:0] out_reg,
  output logic             out_valid,
  input  logic             out_ack,
  output logic             change_lost
);

  localparam logic [7:0] sat = 8'(stable_cycles);

  typedef enum logic {IDLE, PEND} state_t;

  state_t           state;
  logic [width-1:0] cand;
  logic [7:0]       cnt;
  logic [7:0]       cnt_nxt;
  logic [width-1:0] lastq;
  logic [width-1:0] pend_reg;
  logic             pend_flag;
  logic             in_new;
  logic             qual;
  logic             ev;

  assign in_new = (in_reg != cand);

  // Next match count: restart on a new candidate, otherwise count up and
  // saturate so a steady value qualifies only once.
  always_comb begin
    cnt_nxt = cnt;
    if (in_new)
      cnt_nxt = 8'd1;
    else if (cnt < sat)
      cnt_nxt = cnt + 8'd1;
  end

  // Qualify on the edge the count reaches the threshold. The in_new term
  // matters only when stable_cycles is 1: the count then sits at the
  // threshold permanently, so a fresh candidate qualifies immediately.
  assign qual = (cnt_nxt == sat) && ((cnt != sat) || in_new);
  assign ev   = qual && (in_reg != lastq);

  // Candidate tracking and last-qualified value. Reset leaves the counter
  // saturated, so an input of zero held through reset never qualifies.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand  <= '0;
      cnt   <= sat;
      lastq <= '0;
    end else begin
      cand <= in_reg;
      cnt  <= cnt_nxt;
      if (qual)
        lastq <= in_reg;
    end
  end

  // Handshake FSM with a one-deep pending buffer. out_reg stays stable while
  // valid until an ack arrives. Once the buffer is full, any further event
  // overwrites the buffer and raises the sticky loss flag. When an ack and an
  // event land on the same edge, the queue advances, so nothing is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      out_reg     <= '0;
      out_valid   <= 1'b0;
      pend_reg    <= '0;
      pend_flag   <= 1'b0;
      change_lost <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ev) begin
            out_reg   <= in_reg;
            out_valid <= 1'b1;
            state     <= PEND;
          end
        end
        PEND: begin
          if (!out_ack) begin
            if (ev) begin
              pend_reg <= in_reg;
              if (pend_flag)
                change_lost <= 1'b1;
              else
                pend_flag <= 1'b1;
            end
          end else if (!ev) begin
            if (pend_flag) begin
              out_reg   <= pend_reg;
              pend_flag <= 1'b0;
            end else begin
              out_valid <= 1'b0;
              state     <= IDLE;
            end
          end else begin
            if (pend_flag) begin
              out_reg  <= pend_reg;
              pend_reg <= in_reg;
            end else begin
              out_reg <= in_reg;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sync_reg_qualify.sv
// tb_sync_reg_qualify
// Directed bench for sync_reg_qualify with width=8 and stable_cycles=4.
// Inputs change 1 time unit after a rising edge, and outputs are sampled at
// the same point, so every check sees the result of the edge just taken.
module tb_sync_reg_qualify;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_reg;
  logic [7:0] out_reg;
  logic       out_valid;
  logic       out_ack;
  logic       change_lost;

  int checks   = 0;
  int failures = 0;

  sync_reg_qualify #(.width(8), .stable_cycles(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_reg      (in_reg),
    .out_reg     (out_reg),
    .out_valid   (out_valid),
    .out_ack     (out_ack),
    .change_lost (change_lost)
  );

  always #5 clk = ~clk;

  // Every comparison goes through here so the counters stay consistent.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive the inputs, then advance n rising edges and settle just past the last one.
  task automatic applyStimulus(input logic [7:0] value, input logic ack,
                               input logic reset, input int n);
    in_reg  = value;
    out_ack = ack;
    rst     = reset;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with zero input, then hold zero: no event may appear.
    applyStimulus(8'h00, 1'b0, 1'b1, 2);
    checkOutput("rst_out_reg", out_reg, 8'h00);
    checkOutput("rst_valid", out_valid, 1'b0);
    checkOutput("rst_lost", change_lost, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0, 20);
    checkOutput("idle0_valid", out_valid, 1'b0);
    checkOutput("idle0_out_reg", out_reg, 8'h00);
    checkOutput("idle0_lost", change_lost, 1'b0);

    // 0x5A qualifies on the 4th sampling edge; an ack one cycle later drops valid.
    applyStimulus(8'h5A, 1'b0, 1'b0, 3);
    checkOutput("5a_early_valid", out_valid, 1'b0);
    applyStimulus(8'h5A, 1'b0, 1'b0, 1);
    checkOutput("5a_valid", out_valid, 1'b1);
    checkOutput("5a_out_reg", out_reg, 8'h5A);
    applyStimulus(8'h5A, 1'b1, 1'b0, 1);
    checkOutput("5a_ack_valid", out_valid, 1'b0);

    // A glitch that returns to the last qualified value yields no event.
    applyStimulus(8'h11, 1'b0, 1'b0, 3);
    applyStimulus(8'h5A, 1'b0, 1'b0, 6);
    checkOutput("glitch_return_valid", out_valid, 1'b0);
    checkOutput("glitch_return_out_reg", out_reg, 8'h5A);

    // A glitch followed by a new steady value gives exactly one event.
    applyStimulus(8'h11, 1'b0, 1'b0, 3);
    applyStimulus(8'h22, 1'b0, 1'b0, 3);
    checkOutput("22_early_valid", out_valid, 1'b0);
    applyStimulus(8'h22, 1'b0, 1'b0, 1);
    checkOutput("22_valid", out_valid, 1'b1);
    checkOutput("22_out_reg", out_reg, 8'h22);
    applyStimulus(8'h22, 1'b1, 1'b0, 1);
    checkOutput("22_ack_valid", out_valid, 1'b0);
    applyStimulus(8'h22, 1'b0, 1'b0, 5);
    checkOutput("22_no_requal", out_valid, 1'b0);

    // Three changes with no ack: the third overwrites the pending buffer.
    applyStimulus(8'h01, 1'b0, 1'b0, 4);
    checkOutput("ov_first_valid", out_valid, 1'b1);
    checkOutput("ov_first_lost", change_lost, 1'b0);
    applyStimulus(8'h02, 1'b0, 1'b0, 4);
    checkOutput("ov_second_lost", change_lost, 1'b0);
    applyStimulus(8'h03, 1'b0, 1'b0, 4);
    checkOutput("ov_out_reg", out_reg, 8'h01);
    checkOutput("ov_pend_reg", dut.pend_reg, 8'h03);
    checkOutput("ov_lost", change_lost, 1'b1);
    applyStimulus(8'h03, 1'b1, 1'b0, 1);
    checkOutput("ov_ack1_out_reg", out_reg, 8'h03);
    checkOutput("ov_ack1_valid", out_valid, 1'b1);
    applyStimulus(8'h03, 1'b1, 1'b0, 1);
    checkOutput("ov_ack2_valid", out_valid, 1'b0);
    checkOutput("ov_lost_sticky", change_lost, 1'b1);

    // Clear the sticky flag, then ack on the same edge 0x44 qualifies.
    applyStimulus(8'h00, 1'b0, 1'b1, 1);
    checkOutput("clr_lost", change_lost, 1'b0);
    applyStimulus(8'h33, 1'b0, 1'b0, 4);
    checkOutput("33_out_reg", out_reg, 8'h33);
    applyStimulus(8'h44, 1'b0, 1'b0, 3);
    applyStimulus(8'h44, 1'b1, 1'b0, 1);
    checkOutput("ackev_out_reg", out_reg, 8'h44);
    checkOutput("ackev_valid", out_valid, 1'b1);
    checkOutput("ackev_lost", change_lost, 1'b0);
    applyStimulus(8'h44, 1'b1, 1'b0, 1);
    checkOutput("ackev_drain_valid", out_valid, 1'b0);

    // Reset while PEND holds a pending value, then a fresh value qualifies.
    applyStimulus(8'h55, 1'b0, 1'b0, 4);
    applyStimulus(8'h66, 1'b0, 1'b0, 4);
    checkOutput("pre_rst_pend_flag", dut.pend_flag, 1'b1);
    applyStimulus(8'h66, 1'b0, 1'b1, 1);
    checkOutput("midrst_out_reg", out_reg, 8'h00);
    checkOutput("midrst_valid", out_valid, 1'b0);
    checkOutput("midrst_lost", change_lost, 1'b0);
    checkOutput("midrst_pend_flag", dut.pend_flag, 1'b0);
    applyStimulus(8'h7E, 1'b0, 1'b0, 3);
    checkOutput("7e_early_valid", out_valid, 1'b0);
    applyStimulus(8'h7E, 1'b0, 1'b0, 1);
    checkOutput("7e_valid", out_valid, 1'b1);
    checkOutput("7e_out_reg", out_reg, 8'h7E);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
